dmem_mmio: RTL and testbench
============================

// Module: dmem_mmio
// PURPOSE
//  Data-side memory system that sits directly downstream of the pipeline core's
//  Memory stage. It consumes the address, store data, write strobe and access size.
//  It returns a combinational read word within the same cycle.
//  Decodes a word RAM region plus an MMIO page holding a GPIO register, a TX byte
//  FIFO with valid/ready drain, and a free-running 64-bit cycle counter.
// PARAMETERS
//  MP_DATA_WIDTH  32    data width; must be 32
//  MP_MEM_WORDS   1024  RAM depth in 32-bit words; power of 2
//  MP_FIFO_DEPTH  4     TX FIFO entries; power of 2, >=2
// PORTS
//  iclk        in   1   clock, all state on rising edge
//  irst        in   1   synchronous active-high reset
//  iaddr       in   32  byte address (core ALUResultM)
//  iwe         in   1   store strobe (core MemWriteM)
//  isize       in   2   00 byte, 01 half, 10 word (core InstrM); 11 treated as word
//  iwdata      in   32  store data, right-justified (core WriteDataM)
//  ordata      out  32  aligned read word (core ReadDataM); combinational
//  ogpio       out  32  GPIO register
//  otx_valid   out  1   TX FIFO head valid
//  otx_data    out  8   TX FIFO head byte
//  itx_ready   in   1   consumer accepts head when otx_valid & itx_ready
// BEHAVIOUR
//  Map:
//  - iaddr[31]=0 -> RAM; word index iaddr[log2(MP_MEM_WORDS)+1:2]; upper bits ignored (aliasing).
//  - iaddr[31]=1 -> MMIO; offset iaddr[4:2]: 0 GPIO(RW), 1 TXDATA(W), 2 STATUS(RW1C),
//    4 CYCLE_LO(RO), 5 CYCLE_HI(RO); other offsets read 0, writes ignored.
//  Reads:
//  - ordata is a pure function of iaddr and current state; returns the full aligned word.
//  - Lane select and sign extension belong to the core.
//  - STATUS = {26'b0, ovf, count[2:0], empty, full}; count saturates at 7 in the field.
//  Stores (RAM):
//  - Committed at the clock edge when iwe=1.
//  - Byte: lane iaddr[1:0] gets iwdata[7:0].
//  - Half: lanes {iaddr[1],0} and {iaddr[1],1} get iwdata[15:0]; iaddr[0] ignored.
//  - Word: all four lanes; iaddr[1:0] ignored.
//  - Non-written lanes keep their value.
//  - RAM contents are not reset.
//  Stores (MMIO): size is ignored; the full iwdata word is used.
//  - GPIO: ogpio <= iwdata.
//  - TXDATA: push iwdata[7:0] if FIFO not full.
//  - STATUS: iwdata[5]=1 clears ovf.
//  FIFO:
//  - Circular buffer with read/write pointers and count.
//  - otx_valid = (count!=0); otx_data = mem[rptr]. Both come from registers and have
//    no combinational path from iaddr/iwe.
//  - Pop on otx_valid & itx_ready.
//  - Push when full is dropped and sets sticky ovf, even if a pop happens in the same
//    cycle; fullness is judged on the pre-edge state.
//  - Push and pop in the same cycle (not full, not empty): count unchanged, both pointers advance.
//  - Push into an empty FIFO: otx_valid rises the next cycle (latency 1).
//  - Pointers wrap modulo MP_FIFO_DEPTH.
//  - Ovf set and clear in the same cycle: set wins.
//  Cycle counter:
//  - 64-bit, increments every cycle after reset, wraps at 2^64-1 -> 0.
//  - HI/LO reads are not atomic; software re-reads HI.
//  Reset:
//  - ogpio=0, FIFO pointers/count=0, otx_valid=0, ovf=0, counter=0.
//  - A store coincident with irst is discarded.
// CONFIGURATION
//  DMEM_MISALIGN_TRAP_EN defined:
//  - Adds output port omisalign (1 bit), combinational.
//  - omisalign is high when iwe or a RAM access has half with iaddr[0]=1, or word with iaddr[1:0]!=0.
//  - Misaligned stores are suppressed (no RAM/MMIO update).
//  DMEM_MISALIGN_TRAP_EN undefined: no port; low address bits ignored as above.
// TESTING
//  1. Reset, word store 0xDEADBEEF @0x10, read @0x10 -> ordata=0xDEADBEEF same cycle.
//  2. Byte store 0xAA @0x11 over 0xDEADBEEF -> read @0x10 =0xDEADAABE... exact 0xDEADAAEF;
//     half store 0x1234 @0x12 -> 0x1234AAEF.
//  3. itx_ready=0, push 0x41,0x42,0x43,0x44,0x45 -> STATUS full=1, count=4, ovf=1;
//     release ready -> 0x41..0x44 drained in order, 0x45 absent, then otx_valid=0.
//  4. FIFO holds 1 entry, itx_ready=1 and push 0x55 same cycle -> count stays 1, next head=0x55;
//     write STATUS 0x20 -> ovf=0.
//  5. Store 0x0F to GPIO, then irst pulse -> ogpio 0x0F then 0; CYCLE_LO reads 0 first cycle after
//     reset, N after N cycles; force LO=0xFFFFFFFF -> HI increments next cycle.
//  6. DMEM_MISALIGN_TRAP_EN: word store @0x13 -> omisalign=1, RAM word @0x10 unchanged.

Source files
------------

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory with a word RAM plus an MMIO page (GPIO, TX byte FIFO, 64-bit cycle counter)
// Build option DMEM_MISALIGN_TRAP_EN adds omisalign and suppresses misaligned stores.
module dmem_mmio #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_MEM_WORDS  = 1024,
    parameter int MP_FIFO_DEPTH = 4
) (
    input  logic                     iclk,
    input  logic                     irst,
    input  logic [31:0]              iaddr,
    input  logic                     iwe,
    input  logic [1:0]               isize,
    input  logic [MP_DATA_WIDTH-1:0] iwdata,
    output logic [MP_DATA_WIDTH-1:0] ordata,
    output logic [MP_DATA_WIDTH-1:0] ogpio,
    output logic                     otx_valid,
    output logic [7:0]               otx_data,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic                     omisalign,
`endif
    input  logic                     itx_ready
);
    localparam int AW = $clog2(MP_MEM_WORDS);
    localparam int PW = $clog2(MP_FIFO_DEPTH);

    logic [MP_DATA_WIDTH-1:0] ram [MP_MEM_WORDS];
    logic [7:0]               fifo [MP_FIFO_DEPTH];
    logic [PW-1:0]            rptr, wptr;
    logic [PW:0]              count;
    logic                     ovf;
    logic [63:0]              cycle;
    logic                     is_io, mis, we, ram_we, full, push_req, push, pop, clr;
    logic [AW-1:0]            widx;
    logic [2:0]               off, cnt_f;
    logic [3:0]               lanes;
    logic [MP_DATA_WIDTH-1:0] wd, status;
    logic                     unused_addr;

    assign is_io       = iaddr[31];
    assign widx        = iaddr[AW+1:2];
    assign off         = iaddr[4:2];
    assign unused_addr = ^iaddr[30:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis       = (iwe | ~is_io) & ((isize == 2'b01 & iaddr[0]) | (isize[1] & iaddr[1:0] != 2'b00));
    assign omisalign = mis;
`else
    assign mis = 1'b0;
`endif

    // a store coincident with reset or flagged misaligned never commits
    assign we     = iwe & ~mis & ~irst;
    assign ram_we = we & ~is_io;
    assign lanes  = isize[1] ? 4'b1111 : isize[0] ? (iaddr[1] ? 4'b1100 : 4'b0011) : (4'b0001 << iaddr[1:0]);
    assign wd     = isize[1] ? iwdata : isize[0] ? {2{iwdata[15:0]}} : {4{iwdata[7:0]}};

    assign full      = count == (PW+1)'(MP_FIFO_DEPTH);
    assign push_req  = we & is_io & off == 3'd1;
    assign push      = push_req & ~full;
    assign pop       = otx_valid & itx_ready;
    assign clr       = we & is_io & off == 3'd2 & iwdata[5];
    assign otx_valid = count != '0;
    assign otx_data  = fifo[rptr];

    assign cnt_f  = (32'(count) > 32'd7) ? 3'd7 : 3'(count);
    assign status = {26'b0, ovf, cnt_f, ~otx_valid, full};
    assign ordata = ~is_io ? ram[widx] :
                    off == 3'd0 ? ogpio :
                    off == 3'd2 ? status :
                    off == 3'd4 ? cycle[31:0] :
                    off == 3'd5 ? cycle[63:32] : '0;

    // byte-lane RAM write; contents are deliberately not reset
    always_ff @(posedge iclk)
        for (int i = 0; i < 4; i++)
            if (ram_we && lanes[i]) ram[widx][8*i +: 8] <= wd[8*i +: 8];

    // TX FIFO storage, written only on an accepted push
    always_ff @(posedge iclk)
        if (push) fifo[wptr] <= iwdata[7:0];

    // GPIO, FIFO pointers/count, sticky overflow and cycle counter
    always_ff @(posedge iclk) begin
        if (irst) begin
            ogpio <= '0;
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            cycle <= '0;
        end else begin
            cycle <= cycle + 64'd1;
            if (we & is_io & off == 3'd0) ogpio <= iwdata;
            if (push) wptr <= wptr + PW'(1);
            if (pop) rptr <= rptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            ovf   <= (push_req & full) | (ovf & ~clr);
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: vector table, hand sequences and randomized traffic checked against a queue/array model
module tb_dmem_mmio;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [1:0]  sz;
        logic [31:0] wd;
        logic        rdy;
        logic        ck;
        logic [31:0] rd;
        logic        v;
        logic [7:0]  d;
    } vec_t;

    logic        iclk = 1'b0;
    logic        irst, iwe, itx_ready, otx_valid;
    logic [31:0] iaddr, iwdata, ordata, ogpio;
    logic [1:0]  isize;
    logic [7:0]  otx_data;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        omisalign;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ram_m [1024];
    bit          known [1024];
    logic [31:0] gpio_m;
    logic [7:0]  q[$];
    bit          ovf_m;
    logic [63:0] cyc_m;

    dmem_mmio #(.MP_DATA_WIDTH(32), .MP_MEM_WORDS(1024), .MP_FIFO_DEPTH(DEPTH)) dut (
        .iclk(iclk), .irst(irst), .iaddr(iaddr), .iwe(iwe), .isize(isize), .iwdata(iwdata),
        .ordata(ordata), .ogpio(ogpio), .otx_valid(otx_valid), .otx_data(otx_data),
`ifdef DMEM_MISALIGN_TRAP_EN
        .omisalign(omisalign),
`endif
        .itx_ready(itx_ready)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(int a, int w, int sz, int wd, int rdy, int ck, int rd, int v, int d);
        vec_t r;
        r.a = 32'(a); r.w = 1'(w); r.sz = 2'(sz); r.wd = 32'(wd); r.rdy = 1'(rdy);
        r.ck = 1'(ck); r.rd = 32'(rd); r.v = 1'(v); r.d = 8'(d);
        return r;
    endfunction

    function automatic bit mis_m(input logic [31:0] a, input logic w, input logic [1:0] sz);
        return (w || !a[31]) && ((sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0));
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        int n;
        n = q.size();
        if (!a[31]) return ram_m[a[11:2]];
        case (a[4:2])
            3'd0: return gpio_m;
            3'd2: return {26'b0, ovf_m, 3'(n > 7 ? 7 : n), n == 0, n == DEPTH};
            3'd4: return cyc_m[31:0];
            3'd5: return cyc_m[63:32];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step(input vec_t v);
        bit full_pre, blk;
        int idx, nb, base;
        full_pre = q.size() == DEPTH;
        blk = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        blk = mis_m(v.a, v.w, v.sz);
`endif
        cyc_m = cyc_m + 64'd1;
        if (q.size() != 0 && v.rdy) void'(q.pop_front());
        if (v.w && !blk) begin
            if (!v.a[31]) begin
                idx  = int'(v.a[11:2]);
                nb   = v.sz == 2'd0 ? 1 : v.sz == 2'd1 ? 2 : 4;
                base = v.sz == 2'd0 ? int'(v.a[1:0]) : v.sz == 2'd1 ? 2 * int'(v.a[1]) : 0;
                for (int b = 0; b < nb; b++) ram_m[idx][8*(base+b) +: 8] = v.wd[8*b +: 8];
                if (nb == 4) known[idx] = 1'b1;
            end else if (v.a[4:2] == 3'd0) gpio_m = v.wd;
            else if (v.a[4:2] == 3'd1) begin
                if (full_pre) ovf_m = 1'b1;
                else q.push_back(v.wd[7:0]);
            end else if (v.a[4:2] == 3'd2 && v.wd[5]) ovf_m = 1'b0;
        end
    endtask

    task automatic cyc(input vec_t v);
        iaddr = v.a; iwe = v.w; isize = v.sz; iwdata = v.wd; itx_ready = v.rdy;
        #1;
        if (v.a[31] || known[v.a[11:2]]) chk("rd_model", ordata, exp_rd(v.a));
        chk("valid_model", 32'(otx_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("txd_model", 32'(otx_data), 32'(q[0]));
        chk("gpio_model", ogpio, gpio_m);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_model", 32'(omisalign), 32'(mis_m(v.a, v.w, v.sz)));
`endif
        if (v.ck) begin
            chk("vec_rd", ordata, v.rd);
            chk("vec_valid", 32'(otx_valid), 32'(v.v));
            if (v.v) chk("vec_txd", 32'(otx_data), 32'(v.d));
        end
        @(posedge iclk);
        model_step(v);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] a, input logic [31:0] d);
        irst = 1'b1; iaddr = a; iwe = 1'b1; isize = 2'd2; iwdata = d; itx_ready = 1'b0;
        @(posedge iclk);
        #1;
        irst = 1'b0; iwe = 1'b0;
        q.delete(); gpio_m = '0; ovf_m = 1'b0; cyc_m = '0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] r);
        iaddr = a; iwe = 1'b0; isize = 2'd2;
        #1;
        r = ordata;
    endtask

    localparam int TX = 32'h8000_0004;
    localparam int ST = 32'h8000_0008;

    initial begin
        vec_t tbl[$];
        vec_t v;
        logic [31:0] r;
        do_reset(32'h8000_0000, 32'hFFFF_FFFF);
        chk("rst_gpio", ogpio, 32'd0);
        chk("rst_valid", 32'(otx_valid), 32'd0);
        peek(32'h8000_0010, r);
        chk("rst_cycle_lo", r, 32'd0);

        tbl.push_back(mk(32'h10,   1, 2, 32'hDEADBEEF, 0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h10,   0, 2, 0,            0, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(32'h11,   1, 0, 32'h000000AA, 0, 1, 32'hDEADBEEF, 0, 0));
        tbl.push_back(mk(32'h10,   0, 0, 0,            0, 1, 32'hDEADAAEF, 0, 0));
        tbl.push_back(mk(32'h12,   1, 1, 32'h00001234, 0, 1, 32'hDEADAAEF, 0, 0));
        tbl.push_back(mk(32'h10,   0, 2, 0,            0, 1, 32'h1234AAEF, 0, 0));
        tbl.push_back(mk(32'h1010, 0, 2, 0,            0, 1, 32'h1234AAEF, 0, 0));
        tbl.push_back(mk(32'h14,   1, 3, 32'hCAFEF00D, 0, 0, 0, 0, 0));
        tbl.push_back(mk(32'h14,   0, 2, 0,            0, 1, 32'hCAFEF00D, 0, 0));
        tbl.push_back(mk(32'h16,   1, 1, 32'h9999BEEF, 0, 1, 32'hCAFEF00D, 0, 0));
        tbl.push_back(mk(32'h14,   0, 2, 0,            0, 1, 32'hBEEFF00D, 0, 0));
        tbl.push_back(mk(32'h17,   1, 0, 32'h777777C3, 0, 1, 32'hBEEFF00D, 0, 0));
        tbl.push_back(mk(32'h14,   0, 2, 0,            0, 1, 32'hC3EFF00D, 0, 0));
        tbl.push_back(mk(32'h8000_000C, 1, 2, 32'hFFFFFFFF, 0, 1, 0, 0, 0));
        tbl.push_back(mk(32'h8000_0000, 1, 2, 32'h12345678, 0, 1, 0, 0, 0));
        tbl.push_back(mk(32'h8000_0000, 0, 2, 0, 0, 1, 32'h12345678, 0, 0));
        tbl.push_back(mk(32'h8000_0018, 0, 2, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(32'h8000_001C, 0, 2, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(TX, 1, 0, 32'h41, 0, 1, 0, 0, 0));
        tbl.push_back(mk(TX, 1, 0, 32'h42, 0, 1, 0, 1, 32'h41));
        tbl.push_back(mk(TX, 1, 0, 32'h43, 0, 1, 0, 1, 32'h41));
        tbl.push_back(mk(TX, 1, 0, 32'h44, 0, 1, 0, 1, 32'h41));
        tbl.push_back(mk(TX, 1, 0, 32'h45, 0, 1, 0, 1, 32'h41));
        tbl.push_back(mk(ST, 0, 2, 0, 0, 1, 32'h31, 1, 32'h41));
        tbl.push_back(mk(ST, 0, 2, 0, 1, 1, 32'h31, 1, 32'h41));
        tbl.push_back(mk(ST, 0, 2, 0, 1, 1, 32'h2C, 1, 32'h42));
        tbl.push_back(mk(ST, 0, 2, 0, 1, 1, 32'h28, 1, 32'h43));
        tbl.push_back(mk(ST, 0, 2, 0, 1, 1, 32'h24, 1, 32'h44));
        tbl.push_back(mk(ST, 0, 2, 0, 1, 1, 32'h22, 0, 0));
        tbl.push_back(mk(TX, 1, 0, 32'h66, 0, 1, 0, 0, 0));
        tbl.push_back(mk(TX, 1, 0, 32'h55, 1, 1, 0, 1, 32'h66));
        tbl.push_back(mk(ST, 0, 2, 0, 0, 1, 32'h24, 1, 32'h55));
        tbl.push_back(mk(ST, 1, 2, 32'hDF, 0, 1, 32'h24, 1, 32'h55));
        tbl.push_back(mk(ST, 1, 2, 32'h20, 0, 1, 32'h24, 1, 32'h55));
        tbl.push_back(mk(ST, 0, 2, 0, 0, 1, 32'h04, 1, 32'h55));
        tbl.push_back(mk(ST, 0, 2, 0, 1, 1, 32'h04, 1, 32'h55));
        tbl.push_back(mk(ST, 0, 2, 0, 0, 1, 32'h02, 0, 0));
        tbl.push_back(mk(TX, 1, 0, 32'h01, 0, 1, 0, 0, 0));
        tbl.push_back(mk(TX, 1, 0, 32'h02, 0, 1, 0, 1, 32'h01));
        tbl.push_back(mk(TX, 1, 0, 32'h03, 0, 1, 0, 1, 32'h01));
        tbl.push_back(mk(TX, 1, 0, 32'h04, 0, 1, 0, 1, 32'h01));
        tbl.push_back(mk(TX, 1, 0, 32'h05, 1, 1, 0, 1, 32'h01));
        tbl.push_back(mk(ST, 0, 2, 0, 0, 1, 32'h2C, 1, 32'h02));
        tbl.push_back(mk(ST, 0, 2, 0, 1, 1, 32'h2C, 1, 32'h02));
        tbl.push_back(mk(ST, 0, 2, 0, 1, 1, 32'h28, 1, 32'h03));
        tbl.push_back(mk(ST, 0, 2, 0, 1, 1, 32'h24, 1, 32'h04));
        tbl.push_back(mk(ST, 0, 2, 0, 1, 1, 32'h22, 0, 0));
        foreach (tbl[i]) cyc(tbl[i]);

        cyc(mk(32'h8000_0000, 1, 2, 32'h0F, 0, 0, 0, 0, 0));
        chk("gpio_set", ogpio, 32'h0F);
        cyc(mk(TX, 1, 0, 32'h99, 0, 0, 0, 0, 0));
        chk("pre_rst_valid", 32'(otx_valid), 32'd1);
        do_reset(32'h10, 32'h0BADF00D);
        chk("rst2_gpio", ogpio, 32'd0);
        chk("rst2_valid", 32'(otx_valid), 32'd0);
        peek(32'h8000_0010, r);
        chk("rst2_cycle_lo", r, 32'd0);
        peek(32'h10, r);
        chk("rst_store_dropped", r, 32'h1234AAEF);
        repeat (7) cyc(mk(32'h10, 0, 2, 0, 0, 0, 0, 0, 0));
        peek(32'h8000_0010, r);
        chk("cycle_lo_7", r, 32'd7);
        peek(32'h8000_0014, r);
        chk("cycle_hi_0", r, 32'd0);

        cyc(mk(32'h10, 1, 2, 32'hA5A5A5A5, 0, 0, 0, 0, 0));
`ifdef DMEM_MISALIGN_TRAP_EN
        iaddr = 32'h13; iwe = 1'b1; isize = 2'd2; iwdata = 32'hFFFFFFFF;
        #1;
        chk("mis_flag", 32'(omisalign), 32'd1);
        cyc(mk(32'h13, 1, 2, 32'hFFFFFFFF, 0, 0, 0, 0, 0));
        peek(32'h10, r);
        chk("mis_word_kept", r, 32'hA5A5A5A5);
        cyc(mk(32'h11, 1, 1, 32'hBEEF, 0, 0, 0, 0, 0));
        peek(32'h10, r);
        chk("mis_half_kept", r, 32'hA5A5A5A5);
`else
        cyc(mk(32'h13, 1, 2, 32'h01020304, 0, 0, 0, 0, 0));
        peek(32'h10, r);
        chk("noalign_word", r, 32'h01020304);
        cyc(mk(32'h11, 1, 1, 32'hBEEF, 0, 0, 0, 0, 0));
        peek(32'h10, r);
        chk("noalign_half", r, 32'h0102BEEF);
`endif

        for (int k = 0; k < 16; k++) cyc(mk(k * 4, 1, 2, int'($urandom), 0, 0, 0, 0, 0));
        for (int k = 0; k < 1500; k++) begin
            int kind;
            kind  = int'($urandom_range(0, 3));
            v.a   = kind < 2 ? ($urandom & 32'h7FFF_F03F) :
                    kind == 2 ? 32'h8000_0004 : (32'h8000_0000 | ($urandom & 32'h7FFF_FFFF));
            v.w   = 1'($urandom_range(0, 1));
            v.sz  = 2'($urandom_range(0, 3));
            v.wd  = $urandom;
            v.rdy = $urandom_range(0, 3) == 0;
            v.ck  = 1'b0; v.rd = '0; v.v = 1'b0; v.d = '0;
            cyc(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
